decodificador_pwm: RTL and testbench
====================================

Name: decodificador_pwm

Overview:
- Receiving end of the servo PWM link: measures the high time and period of an incoming PWM signal and decodes the width back to the 2-bit position code.
- Covers loopback test of the PWM generator and reading of external PWM sources.
- Reports per-period decode strobe, validity, framing error and loss-of-signal.

Parameters:
conf_periodo, 1_000_000, nominal PWM period in clock cycles (20 ms at 50 MHz)
largura_011, 56250, nominal high width for code 11
largura_010, 68750, nominal high width for code 10
largura_001, 81250, nominal high width for code 01
largura_000, 93750, nominal high width for code 00
tolerancia, 3125, max |width - nominal| accepted, in cycles
tol_periodo, 20000, max |period - conf_periodo| accepted, in cycles
timeout_ciclos, 2_000_000, cycles without a rising edge before loss-of-signal; must be < 2^32

Ports:
clock  in  1  system clock; all logic on rising edge
reset_n  in  1  synchronous, active-low reset
enable  in  1  1 = measure; 0 = hold FSM in INICIAL
pwm_in  in  1  asynchronous PWM input
pos  out  2  last valid decoded position code
valido  out  1  1 while the last completed period decoded correctly
novo  out  1  1-cycle strobe for each successful decode
erro  out  1  1-cycle strobe for each completed period that fails the width or period check
sem_sinal  out  1  loss-of-signal flag
largura  out  32  last measured high width, in cycles
db_estado  out  2  FSM state: INICIAL=00, ALTO=01, BAIXO=10

Behaviour:
- Reset (reset_n=0 at a clock edge): pos=00, valido=0, novo=0, erro=0, sem_sinal=0, largura=0, db_estado=00. Synchronizer and counters are cleared. Reset has priority over everything, including mid-pulse.
- Input path: 2-FF synchronizer to pwm_s, plus a delay register pwm_d.
  - sobe = pwm_s & ~pwm_d
  - desce = ~pwm_s & pwm_d
- Counters, 32 bits each:
  - cont_per: loads 1 on sobe, otherwise increments.
  - cont_alto: loads 1 on sobe, increments while pwm_s=1, and is captured on desce.
  - An N-cycle high pulse measures N. Rise-to-rise spacing P measures P.
- FSM states:
  - INICIAL: desce ignored; on sobe → ALTO. No evaluation, because no prior period exists.
  - ALTO: on desce, latch width into largura and go → BAIXO.
  - BAIXO: on sobe, evaluate the closed period (width latched, period = cont_per before reload), then → ALTO.
- Evaluation, registered and visible in the cycle after the closing sobe:
  - Success requires |periodo - conf_periodo| <= tol_periodo AND |largura - largura_xxx| <= tolerancia for exactly one code xxx.
  - On success: pos=xxx, valido=1, novo=1 for one cycle.
  - Otherwise: erro=1 for one cycle, valido=0, pos holds.
  - All differences are computed unsigned as max-min, with no wrap.
- Latency: novo/erro are high in the cycle after the 3rd rising clock edge following the pwm_in rise that closes the period.
- Timeout: a separate counter clears on sobe and increments otherwise. When it reaches timeout_ciclos:
  - sem_sinal=1, valido=0, FSM → INICIAL; pos holds.
  - This covers both stuck-low and stuck-high inputs.
  - sem_sinal clears on the next sobe; the first good decode needs a further full period.
  - If sobe and timeout occur in the same cycle, sobe wins.
- enable=0: FSM forced to INICIAL, counters cleared, valido=0, sem_sinal=0, novo=erro=0. pos and largura hold. Re-enabling restarts as after reset, minus clearing pos.
- novo and erro are never high in the same cycle.

Optional Feature:
- Macro FILTRO_CONFIRMA_EN.
- When defined: pos updates only when two consecutive successful decodes yield the same code.
  - novo fires only on the period where pos is actually written or re-confirmed.
  - The first success after reset, timeout, erro or enable only arms the filter; no novo.
  - valido follows the same gating.
- When undefined: pos updates on every successful decode, as described above.

Test Plan:
Sim parameters: conf_periodo=1000, largura_011=56, largura_010=69, largura_001=81, largura_000=94, tolerancia=3, tol_periodo=10, timeout_ciclos=2000.
1. Hold reset_n=0 for 3 cycles, then release → all outputs 0, db_estado=00; first pwm_in rise → db_estado=01, no novo.
2. Two periods of 1000 cycles with 94 high → on the 2nd rise, novo pulses once, pos=00, valido=1, largura=94; then widths 81, 69, 57 → pos=01, 10, 11 on successive strobes.
3. Width 75 (out of tolerance), period 1000 → erro pulses once, valido=0, pos stays 11; next 56-high period → novo, pos=11, valido=1.
4. Width 94, period 1011 → erro, valido=0; period 990 → novo (boundary accepted).
5. Hold pwm_in low for 2000 cycles → sem_sinal=1, valido=0, db_estado=00, pos unchanged; then two good periods → sem_sinal clears at the 1st rise, novo at the 2nd.
6. reset_n=0 mid-high-pulse → all outputs and pos reset next edge, no novo/erro; with FILTRO_CONFIRMA_EN, codes 00,01,01 → novo only on the third period, pos=01.

Source files
------------

// File: rtl/decodificador_pwm.sv
// -----------------------------------------------------------------------------
// decodificador_pwm
//
// Receiving end of the servo PWM link. Measures the high time and the period
// of an incoming PWM signal and decodes the high width back into the 2-bit
// position code. Each closed period (rise to rise) is evaluated once, on the
// rising edge that closes it.
//
// Parameters (all in clock cycles):
//   conf_periodo   nominal PWM period
//   largura_011    nominal high width for code 11
//   largura_010    nominal high width for code 10
//   largura_001    nominal high width for code 01
//   largura_000    nominal high width for code 00
//   tolerancia     max |width - nominal| accepted
//   tol_periodo    max |period - conf_periodo| accepted
//   timeout_ciclos cycles without a rising edge before loss-of-signal (< 2^32)
//
// Ports:
//   clock      in   system clock, all logic on the rising edge
//   reset_n    in   synchronous active-low reset
//   enable     in   1 = measure, 0 = hold the FSM in INICIAL
//   pwm_in     in   asynchronous PWM input
//   pos        out  last valid decoded position code
//   valido     out  1 while the last completed period decoded correctly
//   novo       out  1-cycle strobe per successful decode
//   erro       out  1-cycle strobe per completed period that fails a check
//   sem_sinal  out  loss-of-signal flag
//   largura    out  last measured high width
//   db_estado  out  FSM state (INICIAL=00, ALTO=01, BAIXO=10)
//
// Optional feature, macro FILTRO_CONFIRMA_EN: when defined, pos is written
// only when two consecutive successful decodes yield the same code; the first
// success after reset, timeout, erro or enable only arms the filter. valido and
// novo follow the same gating. When undefined, every success updates pos.
// -----------------------------------------------------------------------------
module decodificador_pwm #(
    parameter int unsigned conf_periodo   = 1_000_000,
    parameter int unsigned largura_011    = 56_250,
    parameter int unsigned largura_010    = 68_750,
    parameter int unsigned largura_001    = 81_250,
    parameter int unsigned largura_000    = 93_750,
    parameter int unsigned tolerancia     = 3_125,
    parameter int unsigned tol_periodo    = 20_000,
    parameter int unsigned timeout_ciclos = 2_000_000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        pwm_in,
    output logic [1:0]  pos,
    output logic        valido,
    output logic        novo,
    output logic        erro,
    output logic        sem_sinal,
    output logic [31:0] largura,
    output logic [1:0]  db_estado
);

    localparam logic [31:0] PERIODO_NOM = 32'(conf_periodo);
    localparam logic [31:0] TOL_LARG    = 32'(tolerancia);
    localparam logic [31:0] TOL_PER     = 32'(tol_periodo);
    localparam logic [31:0] TIMEOUT     = 32'(timeout_ciclos);
    // Counter value at which the next non-rise cycle declares loss of signal.
    localparam logic [31:0] TIMEOUT_LIM = TIMEOUT - 32'd1;

    // Nominal widths indexed by the code they decode to.
    localparam logic [31:0] NOMINAL [4] = '{
        32'(largura_000),
        32'(largura_001),
        32'(largura_010),
        32'(largura_011)
    };

    typedef enum logic [1:0] {
        INICIAL = 2'b00,
        ALTO    = 2'b01,
        BAIXO   = 2'b10
    } estado_t;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    // Unsigned distance as max - min, never wraps.
    function automatic logic [31:0] dif_abs(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Saturating increment keeps long stuck inputs from wrapping to small values.
    function automatic logic [31:0] inc_sat(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : (x + 32'd1);
    endfunction

    // -------------------------------------------------------------------------
    // Input synchronizer and edge detection
    // -------------------------------------------------------------------------
    logic [1:0] sinc_reg;
    logic       pwm_d_reg;
    logic       pwm_s;
    logic       sobe;
    logic       desce;

    // The synchronizer keeps running while disabled so that re-enabling in the
    // middle of a high pulse does not fabricate a rising edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sinc_reg  <= 2'b00;
            pwm_d_reg <= 1'b0;
        end else begin
            sinc_reg  <= {sinc_reg[0], pwm_in};
            pwm_d_reg <= sinc_reg[1];
        end
    end

    assign pwm_s = sinc_reg[1];
    assign sobe  = pwm_s & ~pwm_d_reg;
    assign desce = ~pwm_s & pwm_d_reg;

    // -------------------------------------------------------------------------
    // Period, high-time and timeout counters
    // -------------------------------------------------------------------------
    logic [31:0] cont_per_reg;
    logic [31:0] cont_alto_reg;
    logic [31:0] cont_to_reg;
    logic        tempo_esgotado;

    always_ff @(posedge clock) begin
        if (!reset_n || !enable) begin
            cont_per_reg  <= '0;
            cont_alto_reg <= '0;
            cont_to_reg   <= '0;
        end else begin
            // Loading 1 on the rise makes an N-cycle pulse read N and a rise
            // spacing of P read P at the closing rise.
            cont_per_reg <= sobe ? 32'd1 : inc_sat(cont_per_reg);

            if (sobe) begin
                cont_alto_reg <= 32'd1;
            end else if (pwm_s) begin
                cont_alto_reg <= inc_sat(cont_alto_reg);
            end

            if (sobe) begin
                cont_to_reg <= '0;
            end else if (cont_to_reg < TIMEOUT) begin
                cont_to_reg <= cont_to_reg + 32'd1;
            end
        end
    end

    // A rise in the same cycle always wins over the timeout.
    assign tempo_esgotado = enable && !sobe && (cont_to_reg >= TIMEOUT_LIM);

    // -------------------------------------------------------------------------
    // Decode of the latched width and period check
    // -------------------------------------------------------------------------
    logic [31:0] largura_reg;
    logic [3:0]  casa;
    logic [1:0]  codigo;
    logic        unico;
    logic        periodo_ok;
    logic        sucesso;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_casa
            assign casa[gi] = (dif_abs(largura_reg, NOMINAL[gi]) <= TOL_LARG);
        end
    endgenerate

    always_comb begin
        codigo = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (casa[i]) begin
                codigo = 2'(i);
            end
        end
    end

    // Overlapping tolerance windows must not produce an arbitrary code, so the
    // width has to fall inside exactly one window.
    assign unico      = (casa != 4'b0000) && ((casa & (casa - 4'd1)) == 4'b0000);
    // cont_per_reg still holds the closed period during the closing rise.
    assign periodo_ok = (dif_abs(cont_per_reg, PERIODO_NOM) <= TOL_PER);
    assign sucesso    = unico && periodo_ok;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    estado_t estado_reg;
    estado_t estado_next;
    logic    captura;
    logic    avalia;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            estado_reg <= INICIAL;
        end else begin
            estado_reg <= estado_next;
        end
    end

    always_comb begin
        estado_next = estado_reg;
        captura     = 1'b0;
        avalia      = 1'b0;
        if (!enable) begin
            estado_next = INICIAL;
        end else begin
            case (estado_reg)
                INICIAL: begin
                    // No prior period exists, so a falling edge here is ignored.
                    if (sobe) begin
                        estado_next = ALTO;
                    end
                end
                ALTO: begin
                    if (desce) begin
                        captura     = 1'b1;
                        estado_next = BAIXO;
                    end
                end
                BAIXO: begin
                    if (sobe) begin
                        avalia      = 1'b1;
                        estado_next = ALTO;
                    end
                end
                default: begin
                    estado_next = INICIAL;
                end
            endcase
            if (tempo_esgotado) begin
                estado_next = INICIAL;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered results
    // -------------------------------------------------------------------------
    logic [1:0] pos_reg;
    logic       valido_reg;
    logic       novo_reg;
    logic       erro_reg;
    logic       sem_sinal_reg;
`ifdef FILTRO_CONFIRMA_EN
    logic       armado_reg;
    logic [1:0] codigo_armado_reg;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pos_reg       <= 2'b00;
            valido_reg    <= 1'b0;
            novo_reg      <= 1'b0;
            erro_reg      <= 1'b0;
            sem_sinal_reg <= 1'b0;
            largura_reg   <= '0;
`ifdef FILTRO_CONFIRMA_EN
            armado_reg        <= 1'b0;
            codigo_armado_reg <= 2'b00;
`endif
        end else if (!enable) begin
            // pos and largura deliberately hold across a disable.
            valido_reg    <= 1'b0;
            novo_reg      <= 1'b0;
            erro_reg      <= 1'b0;
            sem_sinal_reg <= 1'b0;
`ifdef FILTRO_CONFIRMA_EN
            armado_reg    <= 1'b0;
`endif
        end else begin
            novo_reg <= 1'b0;
            erro_reg <= 1'b0;

            if (captura) begin
                largura_reg <= cont_alto_reg;
            end

            if (sobe) begin
                sem_sinal_reg <= 1'b0;
            end else if (tempo_esgotado) begin
                sem_sinal_reg <= 1'b1;
                valido_reg    <= 1'b0;
`ifdef FILTRO_CONFIRMA_EN
                armado_reg    <= 1'b0;
`endif
            end

            if (avalia) begin
                if (sucesso) begin
`ifdef FILTRO_CONFIRMA_EN
                    if (armado_reg && (codigo_armado_reg == codigo)) begin
                        pos_reg    <= codigo;
                        valido_reg <= 1'b1;
                        novo_reg   <= 1'b1;
                    end else begin
                        valido_reg <= 1'b0;
                    end
                    armado_reg        <= 1'b1;
                    codigo_armado_reg <= codigo;
`else
                    pos_reg    <= codigo;
                    valido_reg <= 1'b1;
                    novo_reg   <= 1'b1;
`endif
                end else begin
                    erro_reg   <= 1'b1;
                    valido_reg <= 1'b0;
`ifdef FILTRO_CONFIRMA_EN
                    armado_reg <= 1'b0;
`endif
                end
            end
        end
    end

    assign pos       = pos_reg;
    assign valido    = valido_reg;
    assign novo      = novo_reg;
    assign erro      = erro_reg;
    assign sem_sinal = sem_sinal_reg;
    assign largura   = largura_reg;
    assign db_estado = estado_reg;

endmodule

// File: tb/tb_decodificador_pwm.sv
// -----------------------------------------------------------------------------
// tb_decodificador_pwm
//
// Directed bench for decodificador_pwm with reduced timing parameters.
// Stimulus pushes the expected outcome of every closed PWM period into a
// queue; an independent monitor pops and compares whenever the DUT strobes
// novo or erro.
// -----------------------------------------------------------------------------
module tb_decodificador_pwm;

    localparam int CONF    = 1000;
    localparam int L011    = 56;
    localparam int L010    = 69;
    localparam int L001    = 81;
    localparam int L000    = 94;
    localparam int TOL     = 3;
    localparam int TOL_PER = 10;
    localparam int TIMEOUT = 2000;

`ifdef FILTRO_CONFIRMA_EN
    localparam bit FILTRO = 1'b1;
`else
    localparam bit FILTRO = 1'b0;
`endif

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable  = 1'b1;
    logic        pwm_in  = 1'b0;
    logic [1:0]  pos;
    logic        valido;
    logic        novo;
    logic        erro;
    logic        sem_sinal;
    logic [31:0] largura;
    logic [1:0]  db_estado;

    always #5 clock = ~clock;

    decodificador_pwm #(
        .conf_periodo  (CONF),
        .largura_011   (L011),
        .largura_010   (L010),
        .largura_001   (L001),
        .largura_000   (L000),
        .tolerancia    (TOL),
        .tol_periodo   (TOL_PER),
        .timeout_ciclos(TIMEOUT)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .enable   (enable),
        .pwm_in   (pwm_in),
        .pos      (pos),
        .valido   (valido),
        .novo     (novo),
        .erro     (erro),
        .sem_sinal(sem_sinal),
        .largura  (largura),
        .db_estado(db_estado)
    );

    typedef struct packed {
        logic        eh_erro;
        logic [1:0]  pos;
        logic [31:0] larg;
    } esperado_t;

    esperado_t fila[$];
    int checks = 0;
    int errors = 0;

    // Reference model state
    bit         tem_anterior = 1'b0;
    int         ant_alto     = 0;
    int         ant_total    = 0;
    bit         armado       = 1'b0;
    logic [1:0] cod_armado   = 2'b00;
    logic [1:0] pos_esp      = 2'b00;
    bit         valido_esp   = 1'b0;

    task automatic checar(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nome, atual, esperado, $time);
        end
    endtask

    function automatic int dif(input int a, input int b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Expected result of a closed period with high width w and period p.
    task automatic modelo_fecha(input int w, input int p);
        int nominais [4];
        int n_casa;
        logic [1:0] cod;
        bit ok;
        esperado_t e;
        nominais = '{L000, L001, L010, L011};
        n_casa = 0;
        cod = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (dif(w, nominais[i]) <= TOL) begin
                n_casa++;
                cod = 2'(i);
            end
        end
        ok = (dif(p, CONF) <= TOL_PER) && (n_casa == 1);
        if (ok) begin
            if (!FILTRO || (armado && cod_armado == cod)) begin
                pos_esp    = cod;
                valido_esp = 1'b1;
                e.eh_erro  = 1'b0;
                e.pos      = cod;
                e.larg     = 32'(w);
                fila.push_back(e);
            end else begin
                valido_esp = 1'b0;
            end
            armado     = 1'b1;
            cod_armado = cod;
        end else begin
            valido_esp = 1'b0;
            armado     = 1'b0;
            e.eh_erro  = 1'b1;
            e.pos      = pos_esp;
            e.larg     = 32'(w);
            fila.push_back(e);
        end
    endtask

    task automatic subir();
        if (tem_anterior) begin
            modelo_fecha(ant_alto, ant_total);
        end
        pwm_in = 1'b1;
    endtask

    // One full period: rise, alto cycles high, then low until total cycles.
    task automatic send(input int alto, input int total);
        subir();
        for (int i = 0; i < alto; i++) begin
            @(posedge clock); #1;
            if (i == 4) checar("estado_alto", 32'(db_estado), 32'd1);
        end
        pwm_in = 1'b0;
        for (int i = 0; i < total - alto; i++) begin
            @(posedge clock); #1;
        end
        checar("estado_baixo", 32'(db_estado), 32'd2);
        tem_anterior = 1'b1;
        ant_alto     = alto;
        ant_total    = total;
    endtask

    task automatic ciclos(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic checar_zero(input string etapa);
        checar({etapa, "_pos"},       32'(pos),       32'd0);
        checar({etapa, "_valido"},    32'(valido),    32'd0);
        checar({etapa, "_novo"},      32'(novo),      32'd0);
        checar({etapa, "_erro"},      32'(erro),      32'd0);
        checar({etapa, "_sem_sinal"}, 32'(sem_sinal), 32'd0);
        checar({etapa, "_largura"},   largura,        32'd0);
        checar({etapa, "_estado"},    32'(db_estado), 32'd0);
    endtask

    // Monitor: one comparison set per novo/erro strobe.
    always @(negedge clock) begin
        esperado_t e;
        if (reset_n && (novo || erro)) begin
            if (novo && erro) begin
                checks++;
                errors++;
                $display("FAIL novo_e_erro: got novo=1 erro=1 expected at most one at %0t", $time);
            end else if (fila.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL evento_inesperado: got novo=%b erro=%b expected none at %0t", novo, erro, $time);
            end else begin
                e = fila.pop_front();
                $display("[%0t] %s pos=%b valido=%b largura=%0d", $time,
                         erro ? "erro" : "novo", pos, valido, largura);
                checar("tipo_erro", 32'(erro),   32'(e.eh_erro));
                checar("pos",       32'(pos),    32'(e.pos));
                checar("valido",    32'(valido), 32'(!e.eh_erro));
                checar("largura",   largura,     e.larg);
            end
        end
    end

    initial begin
        #600_000;
        $display("FAIL watchdog: got no end of stimulus expected finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        // 1. Reset, release, first rise
        reset_n = 1'b0;
        pwm_in  = 1'b0;
        ciclos(3);
        checar_zero("reset");
        reset_n = 1'b1;
        ciclos(1);
        checar_zero("pos_reset");

        // 2. Nominal widths for every code
        send(94, 1000);
        send(94, 1000);
        send(81, 1000);
        send(69, 1000);
        send(57, 1000);

        // 3. Width between windows, then recovery
        send(75, 1000);
        send(56, 1000);

        // 4. Period limits
        send(94, 1011);
        send(94, 990);
        send(94, 1000);

        // 5. Loss of signal with the input stuck low
        n = 0;
        while (!sem_sinal && n < 3000) begin
            @(posedge clock); #1;
            n++;
        end
        checar("sem_sinal_set", 32'(sem_sinal), 32'd1);
        tem_anterior = 1'b0;
        armado       = 1'b0;
        valido_esp   = 1'b0;
        checar("timeout_valido", 32'(valido),    32'd0);
        checar("timeout_estado", 32'(db_estado), 32'd0);
        checar("timeout_pos",    32'(pos),       32'(pos_esp));
        send(94, 1000);
        checar("sem_sinal_clr", 32'(sem_sinal), 32'd0);
        send(94, 1000);

        // 6. Reset in the middle of a high pulse, then 00,01,01
        subir();
        ciclos(20);
        reset_n = 1'b0;
        ciclos(1);
        checar_zero("reset_alto");
        pwm_in = 1'b0;
        ciclos(1);
        reset_n      = 1'b1;
        tem_anterior = 1'b0;
        armado       = 1'b0;
        pos_esp      = 2'b00;
        valido_esp   = 1'b0;
        send(94, 1000);
        send(81, 1000);
        send(81, 1000);
        send(81, 1000);
        ciclos(10);
        checar("filtro_pos",    32'(pos),    32'd1);
        checar("filtro_valido", 32'(valido), 32'(valido_esp));

        // Disable holds pos and largura, clears valido and the FSM
        enable = 1'b0;
        ciclos(3);
        checar("dis_estado",  32'(db_estado), 32'd0);
        checar("dis_valido",  32'(valido),    32'd0);
        checar("dis_pos",     32'(pos),       32'(pos_esp));
        checar("dis_largura", largura,        32'd81);
        enable       = 1'b1;
        tem_anterior = 1'b0;
        armado       = 1'b0;
        valido_esp   = 1'b0;
        send(69, 1000);
        send(69, 1000);
        ciclos(10);
        checar("final_pos",    32'(pos),    32'(pos_esp));
        checar("final_valido", 32'(valido), 32'(valido_esp));
        checar("fila_vazia",   32'(fila.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
